ula_multiciclo: RTL
===================

// Module: ula_multiciclo
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshake; next generation of the processor's datapath ALU.
//  Single-cycle ops and an iterative shift-add multiply.
//  Sits between register-file read and write-back; the control unit stalls on in_ready/out_valid.
// PARAMETERS
//  WIDTH     16  operand/result width in bits (>=4, power of two)
//  SHW       4   shift-amount bits = $clog2(WIDTH); only y[SHW-1:0] used
// PORTS
//  clock         in   1      rising-edge clock
//  reset         in   1      synchronous, active-high
//  in_valid      in   1      operation request present
//  in_ready      out  1      block accepts request this cycle
//  ControleUla   in   4      opcode, sampled at accept
//  x             in   WIDTH  operand A, sampled at accept
//  y             in   WIDTH  operand B, sampled at accept
//  out_valid     out  1      Saida valid
//  out_ready     in   1      consumer takes Saida this cycle
//  Saida         out  WIDTH  result, held stable while out_valid && !out_ready
//  erro          out  1      opcode was illegal; qualified by out_valid
// BEHAVIOUR
//  Opcodes: 0000 add x+y | 0001 sub x-y | 0010 slt (unsigned x<y ? 1 : 0)
//   0011 sll x<<y[SHW-1:0] | 0100 srl x>>y[SHW-1:0] (logical) | 0101 and | 0110 or | 0111 xor
//   1000 mul: low WIDTH bits of x*y (unsigned) | 1001-1111 illegal -> Saida=0, erro=1.
//  All arithmetic modulo 2^WIDTH; y bits above SHW ignored for shifts.
//  FSM: OCIOSO -> (accept, op!=mul) -> PRONTO; OCIOSO -> (accept, mul) -> MULT;
//   MULT: one shift-add step per cycle, counter 0..WIDTH-1; after step WIDTH-1 -> PRONTO.
//   PRONTO -> (out_ready) -> OCIOSO; else hold.
//  Accept = in_valid && in_ready; in_ready = (state==OCIOSO); no acceptance in MULT/PRONTO.
//  Latency: non-mul accept at edge N -> out_valid high after edge N+1 (1 cycle).
//   mul -> out_valid after edge N+WIDTH.
//  out_valid = (state==PRONTO); Saida/erro registered, unchanged until next result.
//  Back-to-back: release in PRONTO costs one OCIOSO cycle; max 1 op / 2 cycles.
//  Operands/opcode latched at accept; input changes afterwards have no effect.
//  in_valid in non-OCIOSO states is ignored (not queued); requester must hold until in_ready.
//  mul with x==0 or y==0 still takes WIDTH cycles (fixed latency).
//  Reset (any state, incl. mid-mul): next edge -> OCIOSO, counter 0, out_valid=0, Saida=0, erro=0.
//   in_ready=1 in the cycle after reset deasserts; partial mul product discarded.
// CONFIGURATION
//  ULA_FLAGS_EN defined: adds outputs zero(1), carry(1), overflow(1), registered with Saida:
//   zero=(Saida==0) all ops; carry=carry-out of add / borrow (x<y unsigned) of sub;
//   overflow=signed overflow of add/sub. carry/overflow=0 for other ops; all 0 at reset.
//  Undefined: ports absent, no flag logic; all other behaviour identical.
// TESTING
//  1 reset held 2 cycles mid-mul -> out_valid=0, Saida=0, in_ready=1 next cycle, no stale result.
//  2 add x=16'hFFFF y=1 -> Saida=0 after 1 cycle; with ULA_FLAGS_EN zero=1 carry=1 overflow=0.
//  3 sub x=3 y=5 -> Saida=16'hFFFE; slt x=3 y=5 -> 1; slt x=16'h8000 y=1 -> 0 (unsigned).
//  4 sll x=1 y=16'h0013 -> Saida=16'h0008 (only y[3:0]=3 used); srl x=16'h8000 y=15 -> 1.
//  5 mul x=300 y=300 -> Saida=16'h5F90 exactly 16 cycles after accept; in_ready=0 throughout.
//  6 out_ready=0 for 5 cycles after result -> Saida/out_valid stable, new in_valid ignored;
//    opcode 4'b1010 -> Saida=0, erro=1.

Source files
------------

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - registered ALU with valid/ready handshake and iterative shift-add multiply
// Optional flags (zero/carry/overflow) enabled by defining ULA_FLAGS_EN.
module ula_multiciclo #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ControleUla,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Saida,
`ifdef ULA_FLAGS_EN
  output logic             zero,
  output logic             carry,
  output logic             overflow,
`endif
  output logic             erro
);

  typedef enum logic [1:0] {OCIOSO, MULT, PRONTO} state_t;

  localparam logic [3:0]     OP_MUL   = 4'b1000;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] saida_q, saida_d;
  logic             erro_q, erro_d;
`ifdef ULA_FLAGS_EN
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
`endif

  logic             accept;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             alu_carry;
  logic             alu_ovf;
  logic [WIDTH-1:0] step_sum;

  assign accept   = in_valid && (state_q == OCIOSO);
  assign sum_ext  = {1'b0, x} + {1'b0, y};
  assign diff_ext = {1'b0, x} - {1'b0, y};
  assign shamt    = y[SHW-1:0];
  assign step_sum = prod_q + (b_q[0] ? a_q : '0);

  // Single-cycle operations; the top bit of diff_ext is the unsigned borrow.
  always_comb begin
    alu_res   = '0;
    alu_err   = 1'b0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (ControleUla)
      4'b0000: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (sum_ext[WIDTH-1] != x[WIDTH-1]);
      end
      4'b0001: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (diff_ext[WIDTH-1] != x[WIDTH-1]);
      end
      4'b0010: alu_res = {{(WIDTH-1){1'b0}}, (x < y)};
      4'b0011: alu_res = x << shamt;
      4'b0100: alu_res = x >> shamt;
      4'b0101: alu_res = x & y;
      4'b0110: alu_res = x | y;
      4'b0111: alu_res = x ^ y;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    saida_d = saida_q;
    erro_d  = erro_q;
`ifdef ULA_FLAGS_EN
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (accept) begin
          if (ControleUla == OP_MUL) begin
            state_d = MULT;
            a_d     = x;
            b_d     = y;
            prod_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = PRONTO;
            saida_d = alu_res;
            erro_d  = alu_err;
`ifdef ULA_FLAGS_EN
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            ovf_d   = alu_ovf;
`endif
          end
        end
      end
      MULT: begin
        prod_d = step_sum;
        a_d    = a_q << 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = PRONTO;
          cnt_d   = '0;
          saida_d = step_sum;
          erro_d  = 1'b0;
`ifdef ULA_FLAGS_EN
          zero_d  = (step_sum == '0);
          carry_d = 1'b0;
          ovf_d   = 1'b0;
`endif
        end
      end
      PRONTO: begin
        if (out_ready) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= OCIOSO;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      saida_q <= '0;
      erro_q  <= 1'b0;
`ifdef ULA_FLAGS_EN
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      saida_q <= saida_d;
      erro_q  <= erro_d;
`ifdef ULA_FLAGS_EN
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == OCIOSO);
  assign out_valid = (state_q == PRONTO);
  assign Saida     = saida_q;
  assign erro      = erro_q;
`ifdef ULA_FLAGS_EN
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
`endif

endmodule
